// File: rtl/exec_pkg.sv
// Shared definitions for the R-type execute stage: function codes, FSM states, defaults.
package exec_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int AW_DEF    = 4;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_NOR = 4'd5;
    localparam logic [3:0] FN_SLT = 4'd6;
    localparam logic [3:0] FN_SLL = 4'd7;
    localparam logic [3:0] FN_SRL = 4'd8;
    localparam logic [3:0] FN_SRA = 4'd9;
    localparam logic [3:0] FN_MUL = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_WB_MUL
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
// done is a combinational pulse in the last iteration cycle; product is valid with it.
module seq_multiplier #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             busy;

    // Partial sum after the current iteration; on the final iteration this is the result.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == CW'(MUL_CYCLES - 1));

    // Operand latch on start, then one add/shift step per cycle while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// R-type execute stage: single-cycle ALU ops written back one cycle after accept,
// MUL handed to the sequential multiplier with the stage stalled until write-back.
module alu_exec_stage
    import exec_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int AW         = AW_DEF,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       funct,
    input  logic [AW-1:0]    rd_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             write,
    output logic [AW-1:0]    rd,
    output logic [WIDTH-1:0] data,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    state_t           state, state_nxt;
    logic             accept, mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [AW-1:0]    mul_rd;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, is_alu;
    logic [4:0]       shamt;

    assign shamt = op_b[4:0];

    seq_multiplier #(
        .WIDTH     (WIDTH),
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (op_a),
        .b      (op_b),
        .done   (mul_done),
        .product(mul_product)
    );

    // Single-cycle datapath; is_alu flags the codes that write back next cycle.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        is_alu  = 1'b1;
        case (funct)
            FN_ADD: begin
                alu_res = op_a + op_b;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            FN_SUB: begin
                alu_res = op_a - op_b;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            FN_AND:  alu_res = op_a & op_b;
            FN_OR:   alu_res = op_a | op_b;
            FN_XOR:  alu_res = op_a ^ op_b;
            FN_NOR:  alu_res = ~(op_a | op_b);
            FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            FN_SLL:  alu_res = op_a << shamt;
            FN_SRL:  alu_res = op_a >> shamt;
            FN_SRA:  alu_res = $signed(op_a) >>> shamt;
            default: is_alu  = 1'b0;
        endcase
    end

    // FSM next state and handshake; only IDLE accepts, MUL accept kicks the multiplier.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        mul_start = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && funct == FN_MUL) begin
                    mul_start = 1'b1;
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL:    if (mul_done) state_nxt = ST_WB_MUL;
            ST_WB_MUL: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Write-back register: write/illegal are pulses, rd/data/flags hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write   <= 1'b0;
            rd      <= '0;
            data    <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
            mul_rd  <= '0;
        end else begin
            write   <= 1'b0;
            illegal <= 1'b0;
            if (mul_start) mul_rd <= rd_in;
            if (accept && is_alu) begin
                write <= 1'b1;
                rd    <= rd_in;
                data  <= alu_res;
                zero  <= (alu_res == '0);
                ovf   <= alu_ovf;
            end else if (accept && !mul_start) begin
                illegal <= 1'b1;
            end
            if (state == ST_MUL && mul_done) begin
                write <= 1'b1;
                rd    <= mul_rd;
                data  <= mul_product;
                zero  <= (mul_product == '0);
                ovf   <= 1'b0;
            end
        end
    end

endmodule
